// File: rtl/wrr_arb_pkg.sv
// Shared types and constants for the weighted round-robin bus arbiter.
package wrr_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    GAP   = 2'd2
  } arb_state_e;

  localparam int DEFAULT_WEIGHT = 1;
  localparam int CFG_DATA_W     = 8;

endpackage

// File: rtl/rr_pick_next.sv
// Combinational round-robin picker: first set mask bit after `last`, wrapping.
module rr_pick_next #(
  parameter int N  = 4,
  parameter int IW = 2
) (
  input  logic [N-1:0]  mask,
  input  logic [IW-1:0] last,
  output logic [N-1:0]  onehot,
  output logic [IW-1:0] idx,
  output logic          valid
);

  localparam int unsigned NU = N;

  always_comb begin
    int unsigned j;
    logic [IW-1:0] j_idx;
    onehot = '0;
    idx    = '0;
    valid  = 1'b0;
    j      = 0;
    j_idx  = '0;
    for (int unsigned i = 1; i <= NU; i++) begin
      j     = (i + {{(32-IW){1'b0}}, last}) % NU;
      j_idx = IW'(j);
      if (!valid && mask[j_idx]) begin
        valid         = 1'b1;
        onehot[j_idx] = 1'b1;
        idx           = j_idx;
      end
    end
  end

endmodule

// File: rtl/wrr_bus_arbiter.sv
// Weighted round-robin bus arbiter with one-cycle turnaround gap between owners.
// Define WRR_ARB_PARK_EN to park the grant on the last owner when the bus is idle.
module wrr_bus_arbiter
  import wrr_arb_pkg::*;
#(
  parameter int NUM_MASTERS = 4,
  parameter int WEIGHT_W    = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NUM_MASTERS-1:0] req,
  output logic [NUM_MASTERS-1:0] grant,
  input  logic                   config_wr,
  input  logic [1:0]             config_addr,
  input  logic [CFG_DATA_W-1:0]  config_data,
  output logic                   busy
);

  localparam int IW = $clog2(NUM_MASTERS);

  arb_state_e             state_q, state_d;
  logic [NUM_MASTERS-1:0] grant_q, grant_d;
  logic [WEIGHT_W-1:0]    quota_q, quota_d;
  logic [IW-1:0]          last_q, last_d;
  logic [WEIGHT_W-1:0]    weight_q [NUM_MASTERS];
  logic [WEIGHT_W-1:0]    weight_d [NUM_MASTERS];

  logic [NUM_MASTERS-1:0] eligible;
  logic [NUM_MASTERS-1:0] pick_onehot;
  logic [IW-1:0]          pick_idx;
  logic                   pick_valid;
  logic                   arbitrate;
  logic                   unused_cfg_hi;

  assign unused_cfg_hi = ^config_data[CFG_DATA_W-1:WEIGHT_W];

  always_comb begin
    for (int unsigned i = 0; i < NUM_MASTERS; i++) begin
      eligible[i] = req[i] && (weight_q[i] != '0);
    end
  end

  rr_pick_next #(
    .N  (NUM_MASTERS),
    .IW (IW)
  ) u_pick (
    .mask   (eligible),
    .last   (last_q),
    .onehot (pick_onehot),
    .idx    (pick_idx),
    .valid  (pick_valid)
  );

  // Writes land on the edge; selection and quota load this cycle see the old weight.
  always_comb begin
    weight_d = weight_q;
    if (config_wr) begin
      weight_d[config_addr] = config_data[WEIGHT_W-1:0];
    end
  end

  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    quota_d   = quota_q;
    last_d    = last_q;
    arbitrate = 1'b0;
    case (state_q)
      IDLE: begin
`ifdef WRR_ARB_PARK_EN
        // A parked grant is held in IDLE; only the parked owner may skip the gap.
        if (grant_q != '0) begin
          if (pick_valid) begin
            if (pick_idx == last_q) begin
              state_d = GRANT;
              quota_d = weight_q[pick_idx];
            end else begin
              state_d = GAP;
              grant_d = '0;
            end
          end
        end else begin
          arbitrate = 1'b1;
        end
`else
        arbitrate = 1'b1;
`endif
      end
      GRANT: begin
        if (req[last_q]) begin
          quota_d = quota_q - 1'b1;
        end
        if (!req[last_q] || quota_q == WEIGHT_W'(1)) begin
          state_d = GAP;
          grant_d = '0;
        end
      end
      GAP: begin
        arbitrate = 1'b1;
      end
      default: begin
        state_d = IDLE;
        grant_d = '0;
      end
    endcase

    if (arbitrate) begin
      if (pick_valid) begin
        state_d = GRANT;
        grant_d = pick_onehot;
        quota_d = weight_q[pick_idx];
        last_d  = pick_idx;
      end else begin
        state_d = IDLE;
        grant_d = '0;
`ifdef WRR_ARB_PARK_EN
        grant_d[last_q] = (weight_q[last_q] != '0);
`endif
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      grant_q <= '0;
      quota_q <= '0;
      last_q  <= IW'(NUM_MASTERS - 1);
      for (int unsigned i = 0; i < NUM_MASTERS; i++) begin
        weight_q[i] <= WEIGHT_W'(DEFAULT_WEIGHT);
      end
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      quota_q  <= quota_d;
      last_q   <= last_d;
      weight_q <= weight_d;
    end
  end

  assign grant = grant_q;
  assign busy  = |grant_q;

endmodule

// File: tb/tb_wrr_bus_arbiter.sv
// Self-checking bench for wrr_bus_arbiter (default build, no bus parking).
module tb_wrr_bus_arbiter;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] req;
  logic [3:0] grant;
  logic       config_wr;
  logic [1:0] config_addr;
  logic [7:0] config_data;
  logic       busy;

  int n_checks = 0;
  int n_pass   = 0;

  // Bus-ownership model: current owner, cycles it may still hold, rotating pointer.
  int m_owner;
  int m_rem;
  int m_ptr;
  int m_w [4];
  bit m_ok = 1'b0;

  always #5 clk = ~clk;

  wrr_bus_arbiter #(
    .NUM_MASTERS (4),
    .WEIGHT_W    (4)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .req         (req),
    .grant       (grant),
    .config_wr   (config_wr),
    .config_addr (config_addr),
    .config_data (config_data),
    .busy        (busy)
  );

  always @(posedge clk) begin
    if (reset) begin
      m_owner = -1;
      m_rem   = 0;
      m_ptr   = 3;
      for (int i = 0; i < 4; i++) m_w[i] = 1;
      m_ok = 1'b1;
    end else begin
      if (m_owner >= 0) begin
        if (req[m_owner]) m_rem = m_rem - 1;
        if (!req[m_owner] || m_rem == 0) m_owner = -1;
      end else begin
        for (int k = 1; k <= 4; k++) begin
          int m;
          m = (m_ptr + k) % 4;
          if (m_owner < 0 && req[m] && m_w[m] > 0) begin
            m_owner = m;
            m_rem   = m_w[m];
            m_ptr   = m;
          end
        end
      end
      if (config_wr) m_w[config_addr] = int'(config_data & 8'h0F);
    end
  end

  function automatic logic [3:0] model_grant();
    logic [3:0] g;
    g = '0;
    if (m_owner >= 0) g[m_owner] = 1'b1;
    return g;
  endfunction

  task automatic chk(input string name, input logic [3:0] got, input logic [3:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %b expected %b at %0t", name, got, exp, $time);
  endtask

  always @(negedge clk) begin
    if (m_ok) begin
      chk("model_grant", grant, model_grant());
      chk("model_busy", {3'b000, busy}, {3'b000, (m_owner >= 0)});
    end
  end

  task automatic drv(input logic rs, input logic [3:0] r, input logic wr,
                     input logic [1:0] a, input logic [7:0] d);
    reset       = rs;
    req         = r;
    config_wr   = wr;
    config_addr = a;
    config_data = d;
    @(negedge clk);
  endtask

  // Hold req for n cycles; pattern lists expected grants, first cycle in the top nibble used.
  task automatic seq(input string name, input logic [3:0] r, input int n, input logic [31:0] pattern);
    for (int k = 0; k < n; k++) begin
      drv(1'b0, r, 1'b0, 2'd0, 8'h00);
      chk(name, grant, pattern[4*(n-1-k) +: 4]);
    end
  endtask

  initial begin
    drv(1'b1, 4'b0000, 1'b0, 2'd0, 8'h00);
    drv(1'b1, 4'b0000, 1'b0, 2'd0, 8'h00);
    chk("reset_grant", grant, 4'b0000);
    chk("reset_busy", {3'b000, busy}, 4'b0000);

    seq("single_w1", 4'b0001, 4, 32'h0000_1010);
    drv(1'b0, 4'b0000, 1'b0, 2'd0, 8'h00);
    chk("idle_no_req", grant, 4'b0000);

    seq("rr_0110", 4'b0110, 6, 32'h0020_4020);
    drv(1'b0, 4'b0000, 1'b0, 2'd0, 8'h00);

    drv(1'b0, 4'b0000, 1'b1, 2'd0, 8'hF3);
    chk("cfg_w3_idle", grant, 4'b0000);
    seq("weight3", 4'b0001, 5, 32'h0001_1101);

    drv(1'b0, 4'b0000, 1'b1, 2'd1, 8'h00);
    chk("drop_to_gap", grant, 4'b0000);
    seq("mask_w0", 4'b0011, 8, 32'h1110_1110);

    drv(1'b0, 4'b0000, 1'b1, 2'd1, 8'h01);
    drv(1'b0, 4'b0000, 1'b0, 2'd0, 8'h00);
    drv(1'b0, 4'b0001, 1'b1, 2'd0, 8'h02);
    chk("old_weight_sel", grant, 4'b0001);
    drv(1'b0, 4'b0001, 1'b1, 2'd0, 8'h01);
    chk("wr_during_grant", grant, 4'b0001);
    seq("quota_kept", 4'b0001, 4, 32'h0000_1010);

    drv(1'b0, 4'b0000, 1'b1, 2'd2, 8'h04);
    drv(1'b0, 4'b0100, 1'b0, 2'd0, 8'h00);
    chk("grant_m2", grant, 4'b0100);
    drv(1'b1, 4'b0101, 1'b0, 2'd0, 8'h00);
    chk("reset_mid_grant", grant, 4'b0000);
    chk("reset_mid_busy", {3'b000, busy}, 4'b0000);
    drv(1'b0, 4'b0101, 1'b0, 2'd0, 8'h00);
    chk("after_reset_m0", grant, 4'b0001);

    for (int c = 0; c < 200; c++) begin
      drv(($urandom_range(0, 40) == 0), 4'($urandom_range(0, 15)),
          ($urandom_range(0, 5) == 0), 2'($urandom_range(0, 3)),
          8'($urandom_range(0, 255)));
      chk("onehot", {3'b000, $countones(grant) <= 1}, 4'b0001);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/wrr_bus_arbiter.md
WRR_BUS_ARBITER -- requirements
Module: wrr_bus_arbiter

Interface
REQ-001 SHALL have parameter NUM_MASTERS, default 4, number of requesters (fixed at 4 for config addressing; 2-bit config_addr).
REQ-002 SHALL have parameter WEIGHT_W, default 4, width of per-master weight and quota counter.
REQ-003 SHALL have port clk, input, 1, single clock; all logic on rising edge.
REQ-004 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-005 SHALL have port req, input, NUM_MASTERS, per-master level request.
REQ-006 SHALL have port grant, output, NUM_MASTERS, registered one-hot (or zero) grant.
REQ-007 SHALL have port config_wr, input, 1, weight write strobe.
REQ-008 SHALL have port config_addr, input, 2, master index for write.
REQ-009 SHALL have port config_data, input, 8, bits [WEIGHT_W-1:0] are the new weight; upper bits ignored.
REQ-010 SHALL have port busy, output, 1, high when any grant is asserted.

Function
REQ-011 SHALL implement FSM states IDLE, GRANT, GAP.
REQ-012 In IDLE, an eligible master (req high, weight nonzero) SHALL cause grant to that master on the next rising edge (1-cycle latency) and a move to GRANT.
REQ-013 Selection SHALL be round-robin: search from (last_granted+1) mod NUM_MASTERS upward with wrap; after reset last_granted = NUM_MASTERS-1, so master 0 has first priority.
REQ-014 On grant, quota counter SHALL load the granted master's weight; each GRANT cycle with that master's req high SHALL decrement it.
REQ-015 GRANT SHALL be left for GAP when the granted req drops or quota reaches 1 and is being decremented (master holds exactly weight cycles max).
REQ-016 GAP SHALL last exactly one cycle with grant = 0 (bus turnaround), then return to IDLE-arbitration (may grant in the following cycle).
REQ-017 Weight 0 SHALL mask the master: never granted regardless of req.
REQ-018 config_wr SHALL update weight[config_addr] on the same edge; a write to the currently granted master SHALL NOT alter its running quota, only its next grant.
REQ-019 Simultaneous config_wr and arbitration in the same cycle SHALL use the old weight for selection and quota load.
REQ-020 grant SHALL never have more than one bit set; busy = |grant.
REQ-021 No requests eligible SHALL keep FSM in IDLE with grant = 0 (unless REQ-026).

Reset
REQ-022 reset SHALL force state IDLE, grant = 0, busy = 0, quota = 0, last_granted = NUM_MASTERS-1.
REQ-023 reset SHALL set every weight to 1.
REQ-024 reset asserted mid-GRANT SHALL drop grant on that same edge; no GAP cycle follows.

Configuration
REQ-025 Macro WRR_ARB_PARK_EN SHALL select bus parking.
REQ-026 With WRR_ARB_PARK_EN defined: in IDLE with no eligible request, grant SHALL park on last_granted master (busy high); a new request from another master SHALL pass through GAP before its grant; parked grant consumes no quota.
REQ-027 Without WRR_ARB_PARK_EN: behaviour per REQ-021; no parking logic compiled.

Structure
REQ-028 A shared package wrr_arb_pkg SHALL hold the state enum (IDLE, GRANT, GAP), the default weight constant (1) and the config data width constant (8).
REQ-029 One sub-module rr_pick_next SHALL be natural: combinational round-robin picker (req mask, last pointer in; one-hot and index out).

Verification
REQ-030 Reset, then req=0001 held 4 cycles -> grant=0001 one cycle after req, 1 cycle grant, GAP (grant=0000), regrant 0001; weight 1 gives alternating 0001/0000.
REQ-031 req=0110 held, weights 1 -> grants alternate 0010, gap, 0100, gap, 0010...
REQ-032 config_wr addr=00 data=0x03, req=0001 held -> grant=0001 for exactly 3 consecutive cycles then 1 gap cycle.
REQ-033 config_wr addr=01 data=0x00, req=0011 -> only 0001 ever granted; 0010 never.
REQ-034 reset pulsed while grant=0100 -> grant=0000 on that edge, next grant to master 0 if req[0] high.
REQ-035 With WRR_ARB_PARK_EN: req=0100 one cycle then 0000 -> grant stays 0100; then req=0001 -> one 0000 gap cycle, then grant=0001.
